// File: rtl/result_unpacker.sv
// Drains a range of 64-bit result-SRAM words and streams each as two 32-bit
// results (lower half first) over a valid/ready interface.
module result_unpacker #(
    parameter int DATA_W        = 32,
    parameter int MEM_WORD_SIZE = 64,
    parameter int ADDR_W        = 9,
    parameter int READ_LATENCY  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        start_addr_i,
    input  logic [ADDR_W-1:0]        end_addr_i,
    output logic                     mem_read_en_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    input  logic [MEM_WORD_SIZE-1:0] mem_rdata_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     last_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_RWAIT,
        S_SEND_LO,
        S_SEND_HI,
        S_END
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [ADDR_W-1:0]        end_q, end_d;
    logic [MEM_WORD_SIZE-1:0] buf_q, buf_d;
    logic [LAT_W-1:0]         cnt_q, cnt_d;
    logic                     is_last;

    assign is_last = (addr_q == end_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            end_q   <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode purely from registered state, so they hold steady under backpressure.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        end_d         = end_q;
        buf_d         = buf_q;
        cnt_d         = cnt_q;
        mem_read_en_o = 1'b0;
        mem_addr_o    = '0;
        data_o        = '0;
        valid_o       = 1'b0;
        last_o        = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d  = start_addr_i;
                    end_d   = end_addr_i;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                busy_o        = 1'b1;
                mem_read_en_o = 1'b1;
                mem_addr_o    = addr_q;
                cnt_d         = '0;
                state_d       = S_RWAIT;
            end
            S_RWAIT: begin
                busy_o = 1'b1;
                if (cnt_q == LAT_LAST) begin
                    buf_d   = mem_rdata_i;
                    state_d = S_SEND_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SEND_LO: begin
                busy_o  = 1'b1;
                valid_o = 1'b1;
                data_o  = buf_q[DATA_W-1:0];
                if (ready_i) begin
                    state_d = S_SEND_HI;
                end
            end
            S_SEND_HI: begin
                busy_o  = 1'b1;
                valid_o = 1'b1;
                data_o  = buf_q[MEM_WORD_SIZE-1:DATA_W];
                last_o  = is_last;
                if (ready_i) begin
                    if (is_last) begin
                        state_d = S_END;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            S_END: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
